// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: sizes, FSM states
// and the circular first-set search used to pick the next owner.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req visiting start, start+1, ..., wrapping modulo n.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input int start, input int n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (start + i) % n;
      if (i < n && !p.found && req[k[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = k[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot to binary encoder in OR-tree form: index bit b is the OR of every
// input whose position has bit b set. All-zero input encodes to 0.
module onehot_to_idx #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     oh_i,
  output logic [IDX_W-1:0] idx_o
);

  for (genvar b = 0; b < IDX_W; b++) begin : g_bit
    logic [N-1:0] sel;
    for (genvar i = 0; i < N; i++) begin : g_in
      assign sel[i] = oh_i[i] & (((i >> b) & 1) == 1);
    end
    assign idx_o[b] = |sel;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, done/drop/hold-limit
// release and back-to-back re-arbitration on release.
module rr_arbiter8 import arb_pkg::*; #(
  parameter int N        = N_REQ,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e        state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic [IDX_W-1:0]  owner;
  logic [N_REQ-1:0]  req_ext;
  logic              limit_hit;
  logic              release_c;
  int                start;
  pick_t             pick;

  onehot_to_idx #(.N(N), .IDX_W(IDX_W)) u_enc (
    .oh_i  (grant_q),
    .idx_o (owner)
  );

  assign req_ext   = N_REQ'(req);
  assign limit_hit = (MAX_HOLD > 0) && (int'(hold_q) == MAX_HOLD - 1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    release_c = 1'b0;
    // While busy the search starts just past the owner, so a still-requesting
    // owner is reached last and only wins when nobody else is asking.
    start     = (state_q == ARB_BUSY) ? (int'(owner) + 1) % N : int'(ptr_q);
    pick      = rr_pick(req_ext, start, N);
    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (pick.found) begin
          grant_d = N'(1) << pick.idx;
          hold_d  = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        release_c = done | ~req[owner] | limit_hit;
        if (release_c) begin
          ptr_d     = IDX_W'((int'(owner) + 1) % N);
          timeout_d = limit_hit & ~done & req[owner];
          hold_d    = '0;
          if (pick.found) begin
            grant_d = N'(1) << pick.idx;
          end else begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = owner;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: a vector table for reset, rotation, gaps
// and hold/drop, plus hand sequences for hold-limit and mid-grant reset.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] req;
  logic [7:0] g0, g1;
  logic [2:0] i0, i1;
  logic       v0, v1, t0, t1;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16)) u0 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g0), .grant_idx(i0), .grant_valid(v0), .timeout(t0)
  );

  rr_arbiter8 #(.MAX_HOLD(4)) u1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g1), .grant_idx(i1), .grant_valid(v1), .timeout(t1)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] g;
    logic [2:0] idx;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [7:0] g, input logic [2:0] ix, input logic to);
    chk({tag, ".grant"}, 32'(g0), 32'(g));
    chk({tag, ".idx"},   32'(i0), 32'(ix));
    chk({tag, ".valid"}, 32'(v0), 32'(g != 8'h00));
    chk({tag, ".tmo"},   32'(t0), 32'(to));
  endtask

  task automatic chk1(input string tag, input logic [7:0] g, input logic [2:0] ix, input logic to);
    chk({tag, ".grant"}, 32'(g1), 32'(g));
    chk({tag, ".idx"},   32'(i1), 32'(ix));
    chk({tag, ".valid"}, 32'(v1), 32'(g != 8'h00));
    chk({tag, ".tmo"},   32'(t1), 32'(to));
  endtask

  function automatic void add(logic r, logic [7:0] q, logic d, logic [7:0] g, logic [2:0] ix);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.g = g; v.idx = ix;
    tv.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; req = 8'hFF; done = 1'b0;

    add(1, 8'hFF, 0, 8'h00, 0);
    add(1, 8'hFF, 0, 8'h00, 0);
    add(0, 8'hFF, 0, 8'h01, 0);
    add(0, 8'hFF, 1, 8'h02, 1);
    add(0, 8'hFF, 1, 8'h04, 2);
    add(0, 8'hFF, 1, 8'h08, 3);
    add(0, 8'hFF, 1, 8'h10, 4);
    add(0, 8'hFF, 1, 8'h20, 5);
    add(0, 8'hFF, 1, 8'h40, 6);
    add(0, 8'hFF, 1, 8'h80, 7);
    add(0, 8'hFF, 1, 8'h01, 0);
    // owner 0 drops, 5 wins; then 5 drops leaving ptr=6 and idle
    add(0, 8'h20, 0, 8'h20, 5);
    add(0, 8'h00, 0, 8'h00, 0);
    add(0, 8'hA4, 0, 8'h80, 7);
    add(0, 8'hA4, 1, 8'h04, 2);
    add(0, 8'hA4, 1, 8'h20, 5);
    add(0, 8'hA4, 1, 8'h80, 7);
    add(0, 8'h08, 0, 8'h08, 3);
    for (int k = 0; k < 5; k++) add(0, 8'h8C, 0, 8'h08, 3);
    add(0, 8'h84, 0, 8'h80, 7);
    add(0, 8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'h00, 0);
    add(0, 8'h01, 1, 8'h01, 0);

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; req = tv[i].req; done = tv[i].done;
      tick();
      chk0($sformatf("vec%0d", i), tv[i].g, tv[i].idx, 1'b0);
    end

    // hold limit of 4 on u1: two requesters, then sole requester, then done+limit
    rst = 1'b1; req = 8'h11; done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk1("to_first", 8'h01, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("to_hold%0d", k + 1), 8'h01, 0, 0);
    end
    tick();
    chk1("to_revoke", 8'h10, 4, 1);
    tick();
    chk1("to_after", 8'h10, 4, 0);
    req = 8'h10;
    tick();
    chk1("sole_h2", 8'h10, 4, 0);
    tick();
    chk1("sole_h3", 8'h10, 4, 0);
    tick();
    chk1("sole_regrant", 8'h10, 4, 1);
    tick();
    chk1("sole_after", 8'h10, 4, 0);
    tick();
    tick();
    done = 1'b1;
    tick();
    chk1("done_prio", 8'h10, 4, 0);
    done = 1'b0;

    // hold limit boundary at 16 on u0
    rst = 1'b1; req = 8'h03;
    tick();
    rst = 1'b0;
    tick();
    chk0("h16_first", 8'h01, 0, 0);
    for (int k = 0; k < 15; k++) tick();
    chk0("h16_last", 8'h01, 0, 0);
    tick();
    chk0("h16_revoke", 8'h02, 1, 1);

    // reset while busy with ptr away from 0
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk0("mr_first", 8'h01, 0, 0);
    done = 1'b1;
    tick();
    chk0("mr_next", 8'h02, 1, 0);
    done = 1'b0;
    tick();
    chk0("mr_hold", 8'h02, 1, 0);
    rst = 1'b1;
    tick();
    chk0("mr_rst", 8'h00, 0, 0);
    chk1("mr_rst1", 8'h00, 0, 0);
    rst = 1'b0;
    tick();
    chk0("mr_restart", 8'h01, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource between N requesters.
- Issues a registered one-hot grant plus its binary index, using the same one-hot-to-binary encoding as the team's Encoder8to3.
- Holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits between requesting units and the shared bus/datapath mux, whose select is driven by grant_idx.

Parameters:
- N, 8, number of requesters (power of two, 2..8).
- IDX_W, 3, index width = log2(N).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; 0 disables the limit.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request per requester, level-sensitive.
- done  input  1  owner finished; sampled only while grant_valid=1.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_idx  output  IDX_W  binary index of the set grant bit; 0 when idle.
- grant_valid  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clock edge): grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE. Reset mid-grant revokes the grant on that edge, with no timeout pulse.
- State machine, two states:
  - IDLE: if req!=0, grant the first set bit searching circularly from ptr. The grant appears on the next edge (1-cycle latency); go to BUSY and set hold_cnt=0. If req=0, stay in IDLE with outputs zero.
  - BUSY: the owner is the set grant bit. A release condition is any of: done=1; req[owner]=0; or MAX_HOLD>0 and hold_cnt==MAX_HOLD-1.
  - BUSY, no release: hold grant, increment hold_cnt. Changes on non-owner req bits are ignored.
- On release:
  - ptr <= owner+1 mod N.
  - Arbitrate in the same cycle, searching from owner+1 over req, excluding the owner if req[owner]=0.
  - A winner gives a back-to-back grant on the next edge with no idle bubble; hold_cnt=0.
  - No winner: grant=0 next edge, state=IDLE.
  - If the owner is the only requester and still requesting (done or timeout), it is re-granted with hold_cnt reset.
- timeout=1 for exactly the cycle after a MAX_HOLD release. If done and the limit coincide, done has priority and timeout stays 0.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx equals the encoded grant.
  - grant_valid = |grant.
- Wrap-around: the search order is ptr, ptr+1, …, N-1, 0, …, ptr-1. Index arithmetic is modulo N in IDX_W bits.
- hold_cnt width is clog2(MAX_HOLD+1); it saturates and is unused when MAX_HOLD=0.
- done is ignored in IDLE.

Decomposition:
- Shared package arb_pkg holds:
  - N_REQ=8 and IDX_W=3;
  - state enum ARB_IDLE/ARB_BUSY;
  - a function for the circular first-set search.
- One sub-module: onehot_to_idx (N-bit one-hot to IDX_W binary, OR-tree form), used for grant_idx.

Test Plan:
- Reset: assert rst with req=8'hFF → grant=0, grant_idx=0, grant_valid=0. Release rst → next edge grant=8'h01, idx=0.
- Rotation: req=8'hFF, pulse done each cycle → grants 01,02,04,…,80,01 back-to-back with no idle cycles. idx steps 0..7 then wraps to 0.
- Fairness with gaps: req=8'b1010_0100, ptr=6, done pulses → grant order 80, 04, 20, 80.
- Hold and drop: owner 3 holds 5 cycles with done=0 → grant stays 8'h08. Owner drops req[3] → next grant goes to the next requester or idle.
- Timeout: MAX_HOLD=4, req=8'h11, owner 0, done=0 → grant revoked after 4 cycles, timeout pulses once, grant=8'h10. Sole requester case: owner re-granted with timeout pulse.
- Mid-grant reset: rst during BUSY → grant=0 on that edge, ptr=0, timeout=0; on deassert the grant restarts from index 0.
